pve_opponent: RTL and testbench

- Computer-controlled second player for PVE mode.
- The game FSM consumes `player2`; this block produces it.
- When the game grants the bot a turn, the block waits a speed-dependent "think" delay, then picks a 2-bit move from a 16-bit LFSR.
- The pick normally avoids matching the human's last move, with a tunable mistake rate.
- It returns the move to the game through a request/valid handshake.

---
 rtl/pve_opponent.sv | 145 ++++++++++++++
 tb/tb_pve_opponent.sv | 302 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pve_opponent.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
//  Module   : pve_opponent
//  Purpose  : Computer-controlled second player. On a granted turn it waits a
//             speed-dependent think delay, then picks a 2-bit move from a
//             16-bit LFSR, usually steering away from the human's move, and
//             presents it with a one-cycle valid pulse.
//  Revision : 1.0 - initial release
// ============================================================================
module pve_opponent #(
    parameter int unsigned DELAY_UNIT  = 1000,
    parameter logic [7:0]  MISS_THRESH = 8'd32,
    parameter logic [15:0] DEF_SEED    = 16'hACE1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        enable,
    input  logic        req,
    input  logic [1:0]  p1_move,
    input  logic [1:0]  speed,
    input  logic [15:0] seed,
    input  logic        seed_load,
    output logic [1:0]  move,
    output logic        move_valid,
    output logic        busy
);

    // Counter must hold D-1 for the slowest speed, i.e. 4*DELAY_UNIT-1.
    localparam int              C_CNT_W   = $clog2(4 * DELAY_UNIT + 1);
    localparam logic [C_CNT_W-1:0] c_CNT_ONE = C_CNT_W'(1);

    localparam logic [1:0] c_IDLE     = 2'd0;
    localparam logic [1:0] c_THINK    = 2'd1;
    localparam logic [1:0] c_DONE     = 2'd2;
    localparam logic [1:0] c_WAIT_REL = 2'd3;

    logic [1:0]         r_state;
    logic [1:0]         w_next_state;
    logic [C_CNT_W-1:0] r_cnt;
    logic [C_CNT_W-1:0] w_load;
    logic [1:0]         r_p1;
    logic [1:0]         r_pick;
    logic [1:0]         r_move;
    logic               r_move_valid;
    logic [15:0]        r_lfsr;
    logic [15:0]        w_seed_eff;
    logic               w_lfsr_fb;
    logic [8:0]         w_thresh_diff;
    logic               w_mistake;
    logic [1:0]         w_cand;
    logic [1:0]         w_pick;

    // A zero seed would lock the LFSR, so it is replaced by the default.
    assign w_seed_eff = (seed == 16'd0) ? DEF_SEED : seed;

    // Taps 16,14,13,11 in right-shifting form: bit 16 of the polynomial is r_lfsr[0].
    assign w_lfsr_fb = r_lfsr[0] ^ r_lfsr[2] ^ r_lfsr[3] ^ r_lfsr[5];

    // Think delay D = (speed+1)*DELAY_UNIT; counter starts at D-1.
    assign w_load = C_CNT_W'((32'(speed) + 32'd1) * DELAY_UNIT - 32'd1);

    // Borrow out of (upper byte - threshold) flags the mistake path (upper < thresh).
    assign w_thresh_diff = {1'b0, r_lfsr[15:8]} - {1'b0, MISS_THRESH};
    assign w_mistake     = w_thresh_diff[8];
    assign w_cand        = r_lfsr[1:0];
    assign w_pick        = (!w_mistake && (w_cand == r_p1)) ? (w_cand + 2'd1) : w_cand;

    // LFSR: free-running, reload (with zero substitution) on reset or seed_load.
    always_ff @(posedge clk) begin
        if (!rst || seed_load) begin
            r_lfsr <= w_seed_eff;
        end else begin
            r_lfsr <= {w_lfsr_fb, r_lfsr[15:1]};
        end
    end

    // State register.
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state <= c_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next-state logic; dropping enable aborts any turn in progress.
    always_comb begin
        w_next_state = r_state;
        if (!enable && (r_state != c_IDLE)) begin
            w_next_state = c_IDLE;
        end else begin
            case (r_state)
                c_IDLE:     if (enable && req) w_next_state = c_THINK;
                c_THINK:    if (r_cnt == '0) w_next_state = c_DONE;
                c_DONE:     w_next_state = req ? c_WAIT_REL : c_IDLE;
                c_WAIT_REL: if (!req) w_next_state = c_IDLE;
                default:    w_next_state = c_IDLE;
            endcase
        end
    end

    // Datapath: latch turn inputs, count the delay, compute and publish the pick.
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_cnt        <= '0;
            r_p1         <= 2'd0;
            r_pick       <= 2'd0;
            r_move       <= 2'd0;
            r_move_valid <= 1'b0;
        end else begin
            r_move_valid <= 1'b0;
            case (r_state)
                c_IDLE: begin
                    if (enable && req) begin
                        r_p1  <= p1_move;
                        r_cnt <= w_load;
                    end
                end
                c_THINK: begin
                    if (enable) begin
                        if (r_cnt != '0) begin
                            r_cnt <= r_cnt - c_CNT_ONE;
                        end else begin
                            r_pick <= w_pick;
                        end
                    end
                end
                c_DONE: begin
                    if (enable) begin
                        r_move       <= r_pick;
                        r_move_valid <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign move       = r_move;
    assign move_valid = r_move_valid;
    assign busy       = (r_state != c_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_pve_opponent.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
//  Module   : tb_pve_opponent
//  Purpose  : Directed self-checking bench for pve_opponent. Two instances
//             share stimulus: one always avoids the human move (threshold 0),
//             one almost always takes the raw LFSR bits (threshold 255).
//  Revision : 1.0 - initial release
// ============================================================================
module tb_pve_opponent;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        enable = 1'b0;
    logic        req = 1'b0;
    logic [1:0]  p1_move = 2'd0;
    logic [1:0]  speed = 2'd0;
    logic [15:0] seed = 16'd0;
    logic        seed_load = 1'b0;

    logic [1:0]  move_a, move_m;
    logic        valid_a, valid_m, busy_a, busy_m;

    int          n_pass  = 0;
    int          n_total = 0;
    logic [15:0] m_lfsr;
    logic [1:0]  last_a = 2'd0;
    logic [1:0]  last_m = 2'd0;

    always #5 clk = ~clk;

    pve_opponent #(.DELAY_UNIT(4), .MISS_THRESH(8'd0), .DEF_SEED(16'hACE1)) u_avoid (
        .clk(clk), .rst(rst), .enable(enable), .req(req), .p1_move(p1_move),
        .speed(speed), .seed(seed), .seed_load(seed_load),
        .move(move_a), .move_valid(valid_a), .busy(busy_a)
    );

    pve_opponent #(.DELAY_UNIT(4), .MISS_THRESH(8'd255), .DEF_SEED(16'hACE1)) u_miss (
        .clk(clk), .rst(rst), .enable(enable), .req(req), .p1_move(p1_move),
        .speed(speed), .seed(seed), .seed_load(seed_load),
        .move(move_m), .move_valid(valid_m), .busy(busy_m)
    );

    function automatic logic [15:0] eff(input logic [15:0] s);
        return (s == 16'd0) ? 16'hACE1 : s;
    endfunction

    function automatic logic [1:0] exp_pick(input logic [15:0] l, input logic [1:0] p1, input int thresh);
        logic [1:0] c;
        c = l[1:0];
        if ((int'(l[15:8]) >= thresh) && (c == p1)) c = c + 2'd1;
        return c;
    endfunction

    // Reference LFSR: x^16+x^14+x^13+x^11, shifting right, new bit into [15].
    always @(posedge clk) begin
        if (!rst || seed_load) m_lfsr <= eff(seed);
        else                   m_lfsr <= {m_lfsr[0] ^ m_lfsr[2] ^ m_lfsr[3] ^ m_lfsr[5], m_lfsr[15:1]};
    end

    // One complete turn; optionally forces the LFSR to fseed at the pick edge.
    task automatic run_turn(input logic [1:0] p1, input logic [1:0] spd, input bit do_seed, input logic [15:0] fseed);
        int d, early;
        logic [15:0] pl;
        logic [1:0] ea, em;
        d = (int'(spd) + 1) * 4;
        early = 0;
        pl = 16'd0;
        @(negedge clk); enable = 1'b1; req = 1'b1; p1_move = p1; speed = spd;
        @(negedge clk); req = 1'b0; p1_move = ~p1; speed = 2'd0;
        n_total++;
        if ({busy_a, busy_m} !== 2'b11) $display("FAIL turn_busy got %b exp 11", {busy_a, busy_m});
        else n_pass++;
        for (int n = 1; n <= d; n++) begin
            @(negedge clk);
            if ({valid_a, valid_m} !== 2'b00) early++;
            seed_load = do_seed && (n == d - 2);
            if (do_seed && (n == d - 2)) seed = fseed;
            if (n == d - 1) pl = m_lfsr;
        end
        n_total++;
        if (early != 0) $display("FAIL turn_early_valid got %0d pulses exp 0", early);
        else n_pass++;
        ea = exp_pick(pl, p1, 0);
        em = exp_pick(pl, p1, 255);
        @(negedge clk);
        n_total++;
        if ({valid_a, valid_m} !== 2'b11) $display("FAIL turn_valid got %b exp 11", {valid_a, valid_m});
        else n_pass++;
        n_total++;
        if (move_a !== ea) $display("FAIL turn_move_avoid got %0d exp %0d lfsr %h", move_a, ea, pl);
        else n_pass++;
        n_total++;
        if (move_m !== em) $display("FAIL turn_move_miss got %0d exp %0d lfsr %h", move_m, em, pl);
        else n_pass++;
        last_a = ea;
        last_m = em;
        @(negedge clk);
        n_total++;
        if ({valid_a, valid_m, busy_a, busy_m} !== 4'b0000)
            $display("FAIL turn_after got %b exp 0000", {valid_a, valid_m, busy_a, busy_m});
        else n_pass++;
    endtask

    task automatic test_reset;
        rst = 1'b0; seed = 16'd0; enable = 1'b0; req = 1'b0;
        repeat (3) @(negedge clk);
        n_total++;
        if ({move_a, move_m, valid_a, valid_m, busy_a, busy_m} !== 8'd0)
            $display("FAIL reset_outputs got %b exp 0", {move_a, move_m, valid_a, valid_m, busy_a, busy_m});
        else n_pass++;
        n_total++;
        if (u_avoid.r_lfsr !== 16'hACE1 || u_miss.r_lfsr !== 16'hACE1)
            $display("FAIL reset_lfsr got %h/%h exp ace1", u_avoid.r_lfsr, u_miss.r_lfsr);
        else n_pass++;
        rst = 1'b1;
    endtask

    task automatic test_basic;
        run_turn(2'd1, 2'd0, 1'b0, 16'd0);
    endtask

    task automatic test_speed;
        run_turn(2'd2, 2'd3, 1'b0, 16'd0);
    endtask

    task automatic test_avoid_wrap;
        run_turn(2'd3, 2'd0, 1'b1, 16'hFF03);
        n_total++;
        if ({move_a, move_m} !== {2'd0, 2'd0}) $display("FAIL wrap_3 got %0d/%0d exp 0/0", move_a, move_m);
        else n_pass++;
        run_turn(2'd1, 2'd0, 1'b1, 16'h8001);
        n_total++;
        if ({move_a, move_m} !== {2'd2, 2'd1}) $display("FAIL avoid_1 got %0d/%0d exp 2/1", move_a, move_m);
        else n_pass++;
    endtask

    task automatic test_mistake;
        run_turn(2'd2, 2'd0, 1'b1, 16'h4C02);
        n_total++;
        if ({move_a, move_m} !== {2'd3, 2'd2}) $display("FAIL mistake_2 got %0d/%0d exp 3/2", move_a, move_m);
        else n_pass++;
        // Zero seed loads ace1: cand 1, upper byte ac
        run_turn(2'd1, 2'd0, 1'b1, 16'h0000);
        n_total++;
        if ({move_a, move_m} !== {2'd2, 2'd1}) $display("FAIL mistake_zero_seed got %0d/%0d exp 2/1", move_a, move_m);
        else n_pass++;
    endtask

    task automatic test_random;
        logic [1:0] p1;
        int hits;
        hits = 0;
        for (int t = 0; t < 200; t++) begin
            p1 = 2'($urandom_range(0, 3));
            run_turn(p1, 2'd0, 1'b1, 16'($urandom));
            if (move_a === p1) hits++;
        end
        n_total++;
        if (hits != 0) $display("FAIL random_avoid got %0d equal moves exp 0", hits);
        else n_pass++;
    endtask

    task automatic test_back_to_back_held;
        int pulses;
        logic [15:0] pl;
        logic [1:0] ea;
        pulses = 0;
        pl = 16'd0;
        @(negedge clk); enable = 1'b1; req = 1'b1; p1_move = 2'd0; speed = 2'd0;
        for (int n = 0; n < 50; n++) begin
            @(negedge clk);
            if (valid_a === 1'b1) pulses++;
            if (n == 3) pl = m_lfsr;
            if (n == 5) begin
                ea = exp_pick(pl, 2'd0, 0);
                last_a = ea;
                last_m = exp_pick(pl, 2'd0, 255);
                n_total++;
                if (move_a !== ea) $display("FAIL held_move got %0d exp %0d", move_a, ea);
                else n_pass++;
            end
        end
        n_total++;
        if (pulses != 1) $display("FAIL held_pulses got %0d exp 1", pulses);
        else n_pass++;
        n_total++;
        if (busy_a !== 1'b1 || u_avoid.r_state !== 2'd3)
            $display("FAIL held_wait_rel got busy %b state %0d exp 1/3", busy_a, u_avoid.r_state);
        else n_pass++;
        req = 1'b0;
        @(negedge clk);
        n_total++;
        if ({busy_a, busy_m} !== 2'b00) $display("FAIL held_release got %b exp 00", {busy_a, busy_m});
        else n_pass++;
    endtask

    task automatic test_abort_enable;
        int pulses;
        pulses = 0;
        @(negedge clk); enable = 1'b1; req = 1'b1; p1_move = 2'd2; speed = 2'd1;
        @(negedge clk); req = 1'b0;
        @(negedge clk); enable = 1'b0;
        @(negedge clk);
        n_total++;
        if ({busy_a, busy_m, valid_a, valid_m} !== 4'b0000)
            $display("FAIL abort_idle got %b exp 0000", {busy_a, busy_m, valid_a, valid_m});
        else n_pass++;
        for (int n = 0; n < 12; n++) begin
            @(negedge clk);
            if ({valid_a, valid_m} !== 2'b00) pulses++;
        end
        n_total++;
        if (pulses != 0) $display("FAIL abort_valid got %0d exp 0", pulses);
        else n_pass++;
        n_total++;
        if ({move_a, move_m} !== {last_a, last_m})
            $display("FAIL abort_move got %0d/%0d exp %0d/%0d", move_a, move_m, last_a, last_m);
        else n_pass++;
        enable = 1'b1;
    endtask

    task automatic test_reset_mid;
        int pulses;
        pulses = 0;
        @(negedge clk); enable = 1'b1; req = 1'b1; p1_move = 2'd1; speed = 2'd1;
        @(negedge clk); req = 1'b0;
        @(negedge clk);
        @(negedge clk); rst = 1'b0;
        @(negedge clk); rst = 1'b1;
        n_total++;
        if ({move_a, move_m, valid_a, valid_m, busy_a, busy_m} !== 8'd0)
            $display("FAIL midreset_outputs got %b exp 0", {move_a, move_m, valid_a, valid_m, busy_a, busy_m});
        else n_pass++;
        last_a = 2'd0;
        last_m = 2'd0;
        for (int n = 0; n < 12; n++) begin
            @(negedge clk);
            if ({valid_a, valid_m, busy_a, busy_m} !== 4'b0000) pulses++;
        end
        n_total++;
        if (pulses != 0) $display("FAIL midreset_quiet got %0d active cycles exp 0", pulses);
        else n_pass++;
    endtask

    task automatic test_seed_reload;
        int early;
        logic [15:0] pl;
        logic [1:0] ea, em;
        early = 0;
        pl = 16'd0;
        @(negedge clk); enable = 1'b1; req = 1'b1; p1_move = 2'd3; speed = 2'd1;
        @(negedge clk); req = 1'b0;
        for (int n = 1; n <= 8; n++) begin
            @(negedge clk);
            if ({valid_a, valid_m} !== 2'b00) early++;
            seed_load = (n == 2);
            if (n == 2) seed = 16'h1234;
            if (n == 3) begin
                n_total++;
                if (u_avoid.r_lfsr !== 16'h1234 || u_miss.r_lfsr !== 16'h1234)
                    $display("FAIL seed_reload got %h/%h exp 1234", u_avoid.r_lfsr, u_miss.r_lfsr);
                else n_pass++;
            end
            if (n == 7) pl = m_lfsr;
        end
        ea = exp_pick(pl, 2'd3, 0);
        em = exp_pick(pl, 2'd3, 255);
        @(negedge clk);
        n_total++;
        if (early != 0 || {valid_a, valid_m} !== 2'b11)
            $display("FAIL seed_delay got early %0d valid %b exp 0/11", early, {valid_a, valid_m});
        else n_pass++;
        n_total++;
        if ({move_a, move_m} !== {ea, em})
            $display("FAIL seed_move got %0d/%0d exp %0d/%0d", move_a, move_m, ea, em);
        else n_pass++;
    endtask

    initial begin
        test_reset();
        test_basic();
        test_speed();
        test_avoid_wrap();
        test_mistake();
        test_back_to_back_held();
        test_abort_enable();
        test_reset_mid();
        test_seed_reload();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog expired after %0d/%0d checks", n_pass, n_total);
        $fatal(1);
    end

endmodule
`default_nettype wire
